// File: rtl/can_pkg.sv
// Shared CAN scheduler types: FSM state encoding, frame field widths and DLC clamp.
package can_pkg;

    localparam int ID_W   = 29;
    localparam int DLC_W  = 4;
    localparam int DATA_W = 64;
    localparam logic [DLC_W-1:0] DLC_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        START  = 2'd2,
        WAIT   = 2'd3
    } can_state_e;

    // Classic CAN carries at most 8 data bytes; codes 9..15 are treated as 8.
    function automatic logic [DLC_W-1:0] clamp_dlc(input logic [DLC_W-1:0] dlc);
        return (dlc > DLC_MAX) ? DLC_MAX : dlc;
    endfunction

endpackage

// File: rtl/can_prio_sel.sv
// Combinational arbiter: picks the pending mailbox with the lowest ID; ties go to the lowest index.
module can_prio_sel
    import can_pkg::*;
#(
    parameter int NUM_MB = 4
) (
    input  logic [NUM_MB-1:0]         pending,
    input  logic [ID_W-1:0]           ids [NUM_MB],
    output logic [$clog2(NUM_MB)-1:0] idx,
    output logic                      valid
);

    localparam int SW = $clog2(NUM_MB);

    logic [ID_W-1:0] best;

    // Strict less-than keeps the earlier (lower) index on equal IDs.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        best  = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pending[i] && (!valid || ids[i] < best)) begin
                idx   = SW'(i);
                valid = 1'b1;
                best  = ids[i];
            end
        end
    end

endmodule

// File: rtl/can_tx_sched.sv
// CAN transmit mailbox scheduler: lowest-ID arbitration, one frame in flight, retry on lost arbitration.
// Optional macro CAN_TX_SCHED_RETRY_LIMIT_EN drops a mailbox after MAX_RETRY+1 consecutive losses.
module can_tx_sched
    import can_pkg::*;
#(
    parameter int NUM_MB    = 4,
    parameter int MAX_RETRY = 15
) (
    input  logic                      clk_can_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic [$clog2(NUM_MB)-1:0] wr_sel_i,
    input  logic [ID_W-1:0]           wr_id_i,
    input  logic [DLC_W-1:0]          wr_dlc_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    output logic                      wr_err_o,
    output logic                      tx_start_o,
    output logic [ID_W-1:0]           tx_id_o,
    output logic [DLC_W-1:0]          tx_dlc_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_lost_i,
    input  logic                      tx_acknowledged_i,
    output logic [NUM_MB-1:0]         pending_o,
    output logic [NUM_MB-1:0]         done_o,
    output logic [NUM_MB-1:0]         fail_o,
    output logic                      busy_o,
    output can_state_e                state_o
);

    localparam int SW = $clog2(NUM_MB);

    // Handshake: tx_start_o is a one-cycle request with tx_* held stable until the
    // transmitter answers with a single tx_acknowledged_i or tx_lost_i pulse in WAIT
    // (ack wins if both); loads are unconditional strobes, rejection reported by wr_err_o.

    can_state_e          state_q, state_d;
    logic [NUM_MB-1:0]   pending_q;
    logic [SW-1:0]       sel_q;
    logic [ID_W-1:0]     id_q   [NUM_MB];
    logic [DLC_W-1:0]    dlc_q  [NUM_MB];
    logic [DATA_W-1:0]   data_q [NUM_MB];
    logic [SW-1:0]       win_idx;
    logic                win_valid;
    logic                wr_hit_sel, wr_ok, wr_rej;
    logic                acked, lost_only, drop_sel;

    can_prio_sel #(.NUM_MB(NUM_MB)) u_prio_sel (
        .pending (pending_q),
        .ids     (id_q),
        .idx     (win_idx),
        .valid   (win_valid)
    );

    assign wr_hit_sel = (state_q != IDLE) && (wr_sel_i == sel_q);
    assign wr_ok      = wr_en_i && !wr_hit_sel && (int'(wr_sel_i) < NUM_MB);
    assign wr_rej     = wr_en_i && !wr_ok;
    assign acked      = (state_q == WAIT) && tx_acknowledged_i;
    assign lost_only  = (state_q == WAIT) && tx_lost_i && !tx_acknowledged_i;
    assign pending_o  = pending_q;
    assign state_o    = state_q;

    always_ff @(posedge clk_can_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        tx_start_o = 1'b0;
        busy_o     = 1'b1;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (win_valid) state_d = SELECT;
            end
            SELECT: state_d = START;
            START: begin
                tx_start_o = 1'b1;
                state_d    = WAIT;
            end
            WAIT: if (tx_acknowledged_i || tx_lost_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_can_i) begin
        if (rst_i) begin
            pending_q <= '0;
            sel_q     <= '0;
            tx_id_o   <= '0;
            tx_dlc_o  <= '0;
            tx_data_o <= '0;
            done_o    <= '0;
            wr_err_o  <= 1'b0;
            for (int i = 0; i < NUM_MB; i++) begin
                id_q[i]   <= '0;
                dlc_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            done_o   <= '0;
            wr_err_o <= wr_rej;
            if (wr_ok) begin
                id_q[wr_sel_i]      <= wr_id_i;
                dlc_q[wr_sel_i]     <= clamp_dlc(wr_dlc_i);
                data_q[wr_sel_i]    <= wr_data_i;
                pending_q[wr_sel_i] <= 1'b1;
            end
            // The frame is captured on entry to SELECT so tx_* is valid for the whole attempt.
            if (state_q == IDLE && win_valid) begin
                sel_q     <= win_idx;
                tx_id_o   <= id_q[win_idx];
                tx_dlc_o  <= dlc_q[win_idx];
                tx_data_o <= data_q[win_idx];
            end
            if (acked) begin
                pending_q[sel_q] <= 1'b0;
                done_o[sel_q]    <= 1'b1;
            end else if (drop_sel) begin
                pending_q[sel_q] <= 1'b0;
            end
        end
    end

`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RW-1:0] retry_q [NUM_MB];

    assign drop_sel = lost_only && (retry_q[sel_q] == RW'(MAX_RETRY));

    always_ff @(posedge clk_can_i) begin
        if (rst_i) begin
            fail_o <= '0;
            for (int i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
        end else begin
            fail_o <= '0;
            if (wr_ok) retry_q[wr_sel_i] <= '0;
            if (acked || drop_sel) retry_q[sel_q] <= '0;
            else if (lost_only) retry_q[sel_q] <= retry_q[sel_q] + RW'(1);
            if (drop_sel) fail_o[sel_q] <= 1'b1;
        end
    end
`else
    // Unlimited retries: fail_o is tied low and MAX_RETRY has no effect in this build.
    assign drop_sel = 1'b0;
    assign fail_o   = {NUM_MB{1'b0}} & {NUM_MB{MAX_RETRY > 0}};
`endif

endmodule

// File: doc/can_tx_sched.md
CAN_TX_SCHED -- requirements
Module: can_tx_sched

Interface
REQ-001 SHALL have parameter NUM_MB, default 4, number of transmit mailboxes (2..8).
REQ-002 SHALL have parameter MAX_RETRY, default 15, retry limit used only when CAN_TX_SCHED_RETRY_LIMIT_EN is defined.
REQ-003 SHALL have port clk_can_i  in  1  CAN bit-rate clock; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have port wr_en_i  in  1  mailbox load strobe.
REQ-006 SHALL have port wr_sel_i  in  $clog2(NUM_MB)  target mailbox.
REQ-007 SHALL have ports wr_id_i  in  29 (extended ID), wr_dlc_i  in  4, wr_data_i  in  64: mailbox contents.
REQ-008 SHALL have port wr_err_o  out  1  one-cycle pulse when a load is rejected.
REQ-009 SHALL have ports tx_start_o  out  1, tx_id_o  out  29, tx_dlc_o  out  4, tx_data_o  out  64: frame request to the CAN transmitter.
REQ-010 SHALL have ports tx_lost_i  in  1 and tx_acknowledged_i  in  1: transmitter outcome pulses.
REQ-011 SHALL have ports pending_o  out  NUM_MB, done_o  out  NUM_MB (one-cycle pulse per index), fail_o  out  NUM_MB (one-cycle pulse per index), busy_o  out  1.

Function
REQ-012 SHALL use FSM states IDLE, SELECT, START, WAIT.
REQ-013 IDLE SHALL go to SELECT in the cycle after any pending bit is set; otherwise IDLE.
REQ-014 SELECT SHALL latch the pending mailbox with the numerically lowest ID (ties: lowest index), drive its ID/DLC/data onto tx_*_o, and go to START.
REQ-015 START SHALL assert tx_start_o for exactly one cycle, then go to WAIT; selection-to-start latency SHALL be 1 cycle.
REQ-016 tx_id_o/tx_dlc_o/tx_data_o SHALL stay stable from SELECT until return to IDLE.
REQ-017 WAIT with tx_acknowledged_i SHALL clear the selected pending bit, pulse done_o[sel], reset that mailbox's retry count, and go to IDLE.
REQ-018 WAIT with tx_lost_i SHALL keep the pending bit, increment the retry count, and go to IDLE to re-arbitrate.
REQ-019 tx_acknowledged_i and tx_lost_i in the same cycle SHALL be treated as acknowledged.
REQ-020 A load to a non-selected mailbox SHALL overwrite its contents, set pending, and clear its retry count in the same cycle.
REQ-021 A load to the mailbox currently selected (SELECT/START/WAIT) SHALL be ignored and SHALL pulse wr_err_o.
REQ-022 wr_dlc_i values above 8 SHALL be stored as 8.
REQ-023 busy_o SHALL be high in every state except IDLE.

Reset
REQ-024 On rst_i, state SHALL be IDLE and the following SHALL be 0: pending, retry counts, tx_start_o, tx_id_o, tx_dlc_o, tx_data_o, done_o, fail_o, wr_err_o, busy_o.
REQ-025 Reset asserted during START or WAIT SHALL abandon the frame; no done_o or fail_o pulse SHALL follow.

Configuration
REQ-026 With CAN_TX_SCHED_RETRY_LIMIT_EN defined, the (MAX_RETRY+1)-th consecutive tx_lost_i for one mailbox SHALL clear its pending bit and pulse fail_o[sel] instead of retrying.
REQ-027 Without CAN_TX_SCHED_RETRY_LIMIT_EN, retries SHALL be unlimited, fail_o SHALL be constant 0, and no retry counters SHALL be synthesized.

Structure
REQ-028 State encoding, the 29-bit ID width, and the maximum DLC constant (8) SHALL live in shared package can_pkg.
REQ-029 Lowest-ID selection SHALL be a combinational sub-module can_prio_sel (inputs: pending vector, ID array; output: winning index and valid).

Verification
REQ-030 Load mailbox 2 with ID 0x100 and mailbox 0 with ID 0x200 in the same cycle span, then ack -> mailbox 2 starts first, done_o[2] pulses, then mailbox 0 starts.
REQ-031 Mailboxes 1 and 3 loaded with equal ID 0x055 -> mailbox 1 is selected first.
REQ-032 Mailbox 0 in WAIT; pulse tx_lost_i and tx_acknowledged_i together -> done_o[0] pulses and pending_o[0]=0.
REQ-033 Mailbox 1 in WAIT; load wr_sel_i=1 -> wr_err_o pulses once and tx_data_o remains unchanged.
REQ-034 Build with the macro and MAX_RETRY=2; issue 3 consecutive tx_lost_i for mailbox 0 -> 3 tx_start_o pulses, fail_o[0] pulses, pending_o[0]=0. Build without the macro -> tx_start_o keeps repeating.
REQ-035 Assert rst_i in WAIT -> next cycle all outputs are 0 and the state is IDLE.
